alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one parameter: bits_size, default 32, the width of the ALU result word.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  ALU result present
- in_ready  out  1  stage can accept
- in_out  in  bits_size  ALU OUT
- in_zero  in  1  ALU Zero
- in_overflow  in  1  ALU oVerflow
- in_negative  in  1  ALU Negative
- in_carry  in  1  ALU Carry
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_data  out  bits_size  head result
- out_zero, out_overflow, out_negative, out_carry  out  1 each  head flags
- count  out  2  entries held, 0..2

Function
REQ-004 The block SHALL be a 2-entry FIFO of {result, zero, overflow, negative, carry} tuples between the combinational ALU and the writeback consumer.
REQ-005 Push SHALL occur on a rising clk edge when in_valid && in_ready.
REQ-006 Pop SHALL occur on a rising clk edge when out_valid && out_ready.
REQ-007 in_ready SHALL be (count != 2) && !rst, decoded from registered state only, with no combinational path from out_ready.
REQ-008 out_valid SHALL be (count != 0).
REQ-009 All out_* data and flag outputs SHALL come directly from the head storage register, with no combinational path from in_* to out_*.
REQ-010 Latency SHALL be 1 cycle: a tuple pushed at edge N SHALL appear on out_* with out_valid=1 after edge N when the FIFO was empty.
REQ-011 Entries SHALL be popped in push order.
REQ-012 Simultaneous push and pop with count=1: count SHALL stay 1 and the head SHALL become the pushed tuple after the edge.
REQ-013 Simultaneous push and pop with count=2 SHALL NOT occur, because in_ready=0; the pop alone SHALL proceed and count SHALL become 1.
REQ-014 Pop with count=0 SHALL be impossible, because out_valid=0; out_ready SHALL then be ignored.
REQ-015 While out_valid=1 and out_ready=0, out_* SHALL hold stable until a pop.
REQ-016 Inputs SHALL be sampled only on push; in_* values outside a push SHALL have no effect.
REQ-017 The storage read/write pointers SHALL be 1 bit each and SHALL wrap 1->0.

Reset
REQ-018 While rst=1 the block SHALL hold: count=0, both pointers=0, out_valid=0, in_ready=0, out_data=0, all out flags=0.
REQ-019 rst SHALL take effect immediately and asynchronously.
REQ-020 Asserting rst mid-operation SHALL discard all held entries.
REQ-021 in_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-022 With macro ALU_RESULT_STICKY_FLAGS_EN defined, the block SHALL add:
- input clr_sticky, 1 bit
- output sticky_flags, 4 bits, ordered {zero, overflow, negative, carry}
REQ-023 With the macro defined, each push SHALL OR the pushed flags into sticky_flags.
REQ-024 With the macro defined, clr_sticky=1 SHALL zero sticky_flags at the edge; clr_sticky together with a push SHALL leave exactly the pushed flags.
REQ-025 With the macro defined, rst SHALL clear sticky_flags to 0.
REQ-026 Without the macro, clr_sticky, sticky_flags and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Single push: after reset, push in_out=32'h0000_00FF, carry=1, out_ready=0 -> next cycle out_valid=1, out_data=32'h0000_00FF, out_carry=1, count=1.
REQ-028 Fill: push 32'h1 then 32'h2 with out_ready=0 -> count=2, in_ready=0, out_data=32'h1; a further in_valid with 32'h3 is not stored.
REQ-029 Drain order: from full {1,2}, out_ready=1 for two cycles -> outputs 32'h1 then 32'h2, then count=0 and out_valid=0.
REQ-030 Simultaneous push/pop at count=1 (head 32'hA, push 32'hB, out_ready=1) -> count stays 1 and out_data=32'hB.
REQ-031 Reset mid-stream: count=2, assert rst between edges -> out_valid=0, count=0, in_ready=0 immediately; in_ready=1 in the first cycle after release.
REQ-032 With ALU_RESULT_STICKY_FLAGS_EN: push overflow=1, then push zero=1 -> sticky_flags=4'b1100; clr_sticky together with a carry=1 push -> sticky_flags=4'b0001.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the writeback consumer.
// The slave modport is the stage; the master modport drives it.
interface alu_result_stage_if #(
  parameter int bits_size = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [bits_size-1:0] in_out;
  logic                 in_zero;
  logic                 in_overflow;
  logic                 in_negative;
  logic                 in_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic [bits_size-1:0] out_data;
  logic                 out_zero;
  logic                 out_overflow;
  logic                 out_negative;
  logic                 out_carry;
  logic [1:0]           count;

  modport slave (
    input  in_valid, in_out, in_zero,
    input  in_overflow, in_negative, in_carry,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_zero, out_overflow,
    output out_negative, out_carry, count
  );

  modport master (
    output in_valid, in_out, in_zero,
    output in_overflow, in_negative, in_carry,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_zero, out_overflow,
    input  out_negative, out_carry, count
  );
endinterface

// File: rtl/alu_result_stage.sv
// 2-entry FIFO of ALU result/flag tuples feeding writeback.
// Optional sticky flag accumulator: define ALU_RESULT_STICKY_FLAGS_EN.
module alu_result_stage #(
  parameter int bits_size = 32
) (
  input  logic clk,
  input  logic rst,
`ifdef ALU_RESULT_STICKY_FLAGS_EN
  input  logic       clr_sticky,
  output logic [3:0] sticky_flags,
`endif
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [bits_size-1:0] data;
    logic                 zero;
    logic                 overflow;
    logic                 negative;
    logic                 carry;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;
  entry_t     in_entry;
  entry_t     head;

  // in_ready only looks at registered count and rst
  assign bus.in_ready  = (count_q != 2'd2) && !rst;
  assign bus.out_valid = (count_q != 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign in_entry = '{
    data:     bus.in_out,
    zero:     bus.in_zero,
    overflow: bus.in_overflow,
    negative: bus.in_negative,
    carry:    bus.in_carry
  };

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.out_data     = head.data;
  assign bus.out_zero     = head.zero;
  assign bus.out_overflow = head.overflow;
  assign bus.out_negative = head.negative;
  assign bus.out_carry    = head.carry;
  assign bus.count        = count_q;

`ifdef ALU_RESULT_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // clear first so a push in the same cycle leaves just its own flags
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 4'b0000;
    end
    if (push) begin
      sticky_d = sticky_d | {bus.in_zero, bus.in_overflow,
                             bus.in_negative, bus.in_carry};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 4'b0000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage.
// Build with ALU_RESULT_STICKY_FLAGS_EN to also cover the sticky flags.
module tb_alu_result_stage;

  logic clk;
  logic rst;
`ifdef ALU_RESULT_STICKY_FLAGS_EN
  logic       clr_sticky;
  logic [3:0] sticky_flags;
`endif

  alu_result_stage_if #(.bits_size(32)) bif ();

  alu_result_stage #(.bits_size(32)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_RESULT_STICKY_FLAGS_EN
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
`endif
    .bus          (bif.slave)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        v;
    logic        n;
    logic        c;
  } tup_t;

  tup_t       sb [$];
  tup_t       exp_t;
  int         total;
  int         bad;
  logic [3:0] sticky_m;
  logic       clr_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic z, input logic o,
                       input logic n, input logic c,
                       input logic ordy, input logic clr);
    bif.in_valid    = v;
    bif.in_out      = d;
    bif.in_zero     = z;
    bif.in_overflow = o;
    bif.in_negative = n;
    bif.in_carry    = c;
    bif.out_ready   = ordy;
    clr_m           = clr;
`ifdef ALU_RESULT_STICKY_FLAGS_EN
    clr_sticky = clr;
`endif
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 64'(bif.count), 64'(sb.size()));
    chk({tag, ".out_valid"}, 64'(bif.out_valid),
        64'(sb.size() != 0));
    chk({tag, ".in_ready"}, 64'(bif.in_ready),
        64'((sb.size() != 2) && !rst));
    if (sb.size() != 0) begin
      chk({tag, ".head"},
          {28'd0, bif.out_data, bif.out_zero, bif.out_overflow,
           bif.out_negative, bif.out_carry},
          64'(sb[0]));
    end
`ifdef ALU_RESULT_STICKY_FLAGS_EN
    chk({tag, ".sticky"}, 64'(sticky_flags), 64'(sticky_m));
`endif
  endtask

  // model decides push/pop from its own occupancy, then advances one edge
  task automatic tick(input string tag);
    logic do_push, do_pop;
    tup_t t;
    do_push = bif.in_valid && (sb.size() != 2);
    do_pop  = bif.out_ready && (sb.size() != 0);
    t = '{d: bif.in_out, z: bif.in_zero, v: bif.in_overflow,
          n: bif.in_negative, c: bif.in_carry};
    if (do_pop) begin
      chk({tag, ".pop"},
          {28'd0, bif.out_data, bif.out_zero, bif.out_overflow,
           bif.out_negative, bif.out_carry},
          64'(sb[0]));
      void'(sb.pop_front());
    end
    if (do_push) sb.push_back(t);
    if (clr_m) sticky_m = 4'b0000;
    if (do_push) sticky_m = sticky_m | {t.z, t.v, t.n, t.c};
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    sticky_m = 4'b0000;
    rst      = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("rst.count", 64'(bif.count), 64'd0);
    chk("rst.out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst.in_ready", 64'(bif.in_ready), 64'd0);
    chk("rst.out_data", 64'(bif.out_data), 64'd0);
    chk("rst.flags",
        64'({bif.out_zero, bif.out_overflow,
             bif.out_negative, bif.out_carry}), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 64'(bif.in_ready), 64'd1);

    drive(1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("single");
    chk("single.data", 64'(bif.out_data), 64'h0000_00FF);
    chk("single.carry", 64'(bif.out_carry), 64'd1);
    chk("single.count", 64'(bif.count), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("single_pop");

    drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("fill1");
    drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("fill2");
    drive(1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("fill_over");
    chk("full.count", 64'(bif.count), 64'd2);
    chk("full.in_ready", 64'(bif.in_ready), 64'd0);
    chk("full.data", 64'(bif.out_data), 64'h1);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("drain1");
    chk("drain1.data", 64'(bif.out_data), 64'h2);
    tick("drain2");
    chk("drain.count", 64'(bif.count), 64'd0);
    chk("drain.out_valid", 64'(bif.out_valid), 64'd0);
    tick("empty_pop");

    drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("pp_head");
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("pp");
    chk("pp.count", 64'(bif.count), 64'd1);
    chk("pp.data", 64'(bif.out_data), 64'hB);
    drive(1'b0, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("hold1");
    drive(1'b0, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("hold2");
    chk("hold.data", 64'(bif.out_data), 64'hB);

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
      tick("rand");
    end

    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("pre_rst1");
    tick("pre_rst2");
    chk("pre_rst.count", 64'(bif.count), 64'd2);
    rst = 1'b1;
    #1;
    sb.delete();
    sticky_m = 4'b0000;
    chk("midrst.out_valid", 64'(bif.out_valid), 64'd0);
    chk("midrst.count", 64'(bif.count), 64'd0);
    chk("midrst.in_ready", 64'(bif.in_ready), 64'd0);
    chk("midrst.out_data", 64'(bif.out_data), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrel.in_ready", 64'(bif.in_ready), 64'd1);
    tick("post_rst");

`ifdef ALU_RESULT_STICKY_FLAGS_EN
    drive(1'b1, 32'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("st_ov");
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("st_z");
    chk("sticky.1100", 64'(sticky_flags), 64'b1100);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick("st_clr_push");
    chk("sticky.0001", 64'(sticky_flags), 64'b0001);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick("st_clr");
    chk("sticky.0000", 64'(sticky_flags), 64'b0000);
`endif

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("final1");
    tick("final2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
